// File: rtl/mem_arbiter_pkg.sv
// Shared cache-layer types for the memory arbiter: bus widths, line geometry,
// arbiter state and transaction-owner encodings, and the latched command payload.
package mem_arbiter_pkg;

  localparam int unsigned LINE_BEATS = 8;
  localparam int unsigned OFFSET_W   = 5;

  typedef logic [31:0]              bus32_t;
  typedef logic [32*LINE_BEATS-1:0] bus256_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRESP,
    DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    DWR,
    DRD,
    IUC,
    IRD
  } owner_e;

  // Memory-side command captured at grant and held for the whole transaction.
  typedef struct packed {
    logic       we;
    bus32_t     addr;
    logic [2:0] len;
    bus32_t     wdata;
    logic [3:0] wstrb;
  } mem_cmd_t;

endpackage

// File: rtl/mem_line_assembler.sv
// Collects 32-bit read beats into one cache line.
// Ports: clk, reset (sync, active-high); clear restarts assembly at beat 0 with
// an empty line; beat_valid/beat_data present one beat; line_c is the line
// including the beat being presented this cycle, so a completion can capture
// the full line on the same edge that takes the final beat.
module mem_line_assembler #(
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      beat_valid,
  input  logic [31:0]               beat_data,
  output logic [32*LINE_BEATS-1:0]  line_c
);
  import mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned IDX_W = CNT_W + 5;

  logic [CNT_W-1:0]          cnt_q;
  logic                      full_q;
  logic [32*LINE_BEATS-1:0]  line_q;
  logic                      take_c;
  logic [IDX_W-1:0]          idx_c;

  // Beats past the end of the line are dropped; the bus rlast decides completion.
  assign take_c = beat_valid && !full_q;
  assign idx_c  = {cnt_q, 5'b0};

  // Insert the presented beat at its slot.
  always_comb begin
    line_c = line_q;
    if (take_c) begin
      line_c[idx_c +: 32] = beat_data;
    end
  end

  // Beat counter and line storage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      line_q <= '0;
    end else begin
      line_q <= line_c;
      if (take_c) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LINE_BEATS - 1)) begin
          full_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one 32-bit memory port between the icache
// refill, the icache uncached fetch and the dcache (refill and word write).
// Ports: clk, reset (sync, active-high); icache refill rd_*/ret_*; icache
// uncached iucache_*; dcache refill drd_*/dret_*; dcache write dwr_*;
// memory side mem_* (request/accept, read beats, write response).
module mem_arbiter #(
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned OFFSET_W   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [31:0]               rd_addr,
  output logic                      ret_valid,
  output logic [32*LINE_BEATS-1:0]  ret_data,
  input  logic                      iucache_ren_i,
  input  logic [31:0]               iucache_addr_i,
  output logic                      iucache_rvalid_o,
  output logic [31:0]               iucache_rdata_o,
  input  logic                      drd_req,
  input  logic [31:0]               drd_addr,
  output logic                      dret_valid,
  output logic [32*LINE_BEATS-1:0]  dret_data,
  input  logic                      dwr_req,
  input  logic [31:0]               dwr_addr,
  input  logic [31:0]               dwr_data,
  input  logic [3:0]                dwr_strb,
  output logic                      dwr_ok,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [2:0]                mem_len,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_rlast,
  input  logic                      mem_bvalid
);
  import mem_arbiter_pkg::*;

  localparam bus32_t LINE_MASK = ~bus32_t'((32'd1 << OFFSET_W) - 32'd1);

  arb_state_e               state_q, state_d;
  owner_e                   owner_q, win_c;
  mem_cmd_t                 cmd_q, win_cmd_c;
  logic                     any_req_c;
  logic                     grant_c;
  logic                     done_c;
  logic [32*LINE_BEATS-1:0] line_c;

  assign any_req_c = dwr_req || drd_req || iucache_ren_i || rd_req;
  assign grant_c   = (state_q == IDLE) && any_req_c;
  // DONE is only entered from DATA or WRESP, so this marks a completing edge.
  assign done_c    = (state_d == DONE);

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_len   = cmd_q.len;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wstrb = cmd_q.wstrb;

  // Priority select of the winner and its memory command.
  always_comb begin
    win_c     = IRD;
    win_cmd_c = '0;
    if (dwr_req) begin
      win_c           = DWR;
      win_cmd_c.we    = 1'b1;
      win_cmd_c.addr  = dwr_addr;
      win_cmd_c.wdata = dwr_data;
      win_cmd_c.wstrb = dwr_strb;
    end else if (drd_req) begin
      win_c          = DRD;
      win_cmd_c.addr = drd_addr & LINE_MASK;
      win_cmd_c.len  = 3'(LINE_BEATS - 1);
    end else if (iucache_ren_i) begin
      win_c          = IUC;
      win_cmd_c.addr = iucache_addr_i;
    end else begin
      win_cmd_c.addr = rd_addr & LINE_MASK;
      win_cmd_c.len  = 3'(LINE_BEATS - 1);
    end
  end

  // Next-state logic; DONE never grants, so a lingering req is not re-issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_c) state_d = ADDR;
      ADDR:    if (mem_ready) state_d = cmd_q.we ? WRESP : DATA;
      DATA:    if (mem_rvalid && mem_rlast) state_d = DONE;
      WRESP:   if (mem_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command, done pulses and per-owner result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= IRD;
      cmd_q            <= '0;
      mem_req          <= 1'b0;
      ret_valid        <= 1'b0;
      dret_valid       <= 1'b0;
      iucache_rvalid_o <= 1'b0;
      dwr_ok           <= 1'b0;
      ret_data         <= '0;
      dret_data        <= '0;
      iucache_rdata_o  <= '0;
    end else begin
      state_q          <= state_d;
      mem_req          <= (state_d == ADDR);
      ret_valid        <= done_c && (owner_q == IRD);
      dret_valid       <= done_c && (owner_q == DRD);
      iucache_rvalid_o <= done_c && (owner_q == IUC);
      dwr_ok           <= done_c && (owner_q == DWR);
      if (grant_c) begin
        owner_q <= win_c;
        cmd_q   <= win_cmd_c;
      end
      if (done_c && (owner_q == IRD)) ret_data        <= line_c;
      if (done_c && (owner_q == DRD)) dret_data       <= line_c;
      if (done_c && (owner_q == IUC)) iucache_rdata_o <= line_c[31:0];
    end
  end

  mem_line_assembler #(
    .LINE_BEATS (LINE_BEATS)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (grant_c),
    .beat_valid ((state_q == DATA) && mem_rvalid),
    .beat_data  (mem_rdata),
    .line_c     (line_c)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the memory side is driven
// inline by the stimulus sequence. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic         iucache_ren_i;
  logic [31:0]  iucache_addr_i;
  logic         iucache_rvalid_o;
  logic [31:0]  iucache_rdata_o;
  logic         drd_req;
  logic [31:0]  drd_addr;
  logic         dret_valid;
  logic [255:0] dret_data;
  logic         dwr_req;
  logic [31:0]  dwr_addr;
  logic [31:0]  dwr_data;
  logic [3:0]   dwr_strb;
  logic         dwr_ok;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [2:0]   mem_len;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;
  logic         mem_bvalid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .ret_valid        (ret_valid),
    .ret_data         (ret_data),
    .iucache_ren_i    (iucache_ren_i),
    .iucache_addr_i   (iucache_addr_i),
    .iucache_rvalid_o (iucache_rvalid_o),
    .iucache_rdata_o  (iucache_rdata_o),
    .drd_req          (drd_req),
    .drd_addr         (drd_addr),
    .dret_valid       (dret_valid),
    .dret_data        (dret_data),
    .dwr_req          (dwr_req),
    .dwr_addr         (dwr_addr),
    .dwr_data         (dwr_data),
    .dwr_strb         (dwr_strb),
    .dwr_ok           (dwr_ok),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_len          (mem_len),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_rlast        (mem_rlast),
    .mem_bvalid       (mem_bvalid)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + step * 32'(i);
    return l;
  endfunction

  function automatic logic [3:0] pulses();
    return {ret_valid, dret_valid, iucache_rvalid_o, dwr_ok};
  endfunction

  // Wait for mem_req, check the command, stall `delay` cycles, then accept.
  task automatic accept(input string tag, input int delay, input logic we,
                        input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req"}, 256'(mem_req), 256'(1'b1));
    check({tag, "_cmd"}, 256'({mem_we, mem_addr, mem_len}), 256'({we, addr, len}));
    if (we) check({tag, "_wdat"}, 256'({mem_wdata, mem_wstrb}), 256'({wdata, wstrb}));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d", tag, i), 256'({mem_req, mem_we, mem_addr, mem_len}),
            256'({1'b1, we, addr, len}));
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check({tag, "_reqdrop"}, 256'(mem_req), 256'(1'b0));
  endtask

  // Drive n consecutive read beats base+step*i; rlast on the final one if asked.
  task automatic beats(input int n, input logic [31:0] base, input logic [31:0] step,
                       input logic with_last);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + step * 32'(i);
      mem_rlast  = with_last && (i == n - 1);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_req = 1'b0;          rd_addr = '0;
    iucache_ren_i = 1'b0;   iucache_addr_i = '0;
    drd_req = 1'b0;         drd_addr = '0;
    dwr_req = 1'b0;         dwr_addr = '0; dwr_data = '0; dwr_strb = '0;
    mem_ready = 1'b0;       mem_rvalid = 1'b0; mem_rdata = '0;
    mem_rlast = 1'b0;       mem_bvalid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_mem", 256'({mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wstrb}), '0);
    check("rst_pulse", 256'(pulses()), '0);
    check("rst_ret", ret_data, '0);
    check("rst_dret", dret_data, '0);
    check("rst_iuc", 256'(iucache_rdata_o), '0);
    reset = 1'b0;
    @(negedge clk);

    // Single icache refill, unaligned address
    rd_addr = 32'h0080_0014; rd_req = 1'b1; c0 = cyc;
    accept("t1", 0, 1'b0, 32'h0080_0000, 3'd7, '0, '0);
    beats(8, 32'h0080_0000, 32'd4, 1'b1);
    check("t1_pulse", 256'(pulses()), 256'(4'b1000));
    check("t1_data", ret_data, line_of(32'h0080_0000, 32'd4));
    check("t1_lat", 256'(cyc - c0), 256'(10));
    rd_req = 1'b0;
    @(negedge clk);
    check("t1_once", 256'({pulses(), mem_req}), '0);

    // Uncached read, exact address
    iucache_addr_i = 32'h0000_0008; iucache_ren_i = 1'b1;
    accept("t2", 0, 1'b0, 32'h0000_0008, 3'd0, '0, '0);
    beats(1, 32'hff00_0008, 32'd0, 1'b1);
    check("t2_pulse", 256'(pulses()), 256'(4'b0010));
    check("t2_data", 256'(iucache_rdata_o), 256'(32'hff00_0008));
    check("t2_ret_hold", ret_data, line_of(32'h0080_0000, 32'd4));
    iucache_ren_i = 1'b0;
    @(negedge clk);
    check("t2_once", 256'(pulses()), '0);

    // Simultaneous write, dcache refill and icache refill
    dwr_addr = 32'h0000_2004; dwr_data = 32'hdead_beef; dwr_strb = 4'b0110;
    drd_addr = 32'h0000_401c; rd_addr = 32'h0080_0040;
    dwr_req = 1'b1; drd_req = 1'b1; rd_req = 1'b1;
    accept("t3w", 0, 1'b1, 32'h0000_2004, 3'd0, 32'hdead_beef, 4'b0110);
    mem_bvalid = 1'b1;
    @(negedge clk);
    mem_bvalid = 1'b0;
    check("t3w_pulse", 256'(pulses()), 256'(4'b0001));
    dwr_req = 1'b0;
    @(negedge clk);
    check("t3w_gap", 256'({pulses(), mem_req}), '0);
    accept("t3d", 0, 1'b0, 32'h0000_4000, 3'd7, '0, '0);
    // Ninth beat with rlast: the extra beat is dropped, rlast still completes.
    beats(9, 32'h1111_0000, 32'h10, 1'b1);
    check("t3d_pulse", 256'(pulses()), 256'(4'b0100));
    check("t3d_data", dret_data, line_of(32'h1111_0000, 32'h10));
    check("t3d_ret_hold", ret_data, line_of(32'h0080_0000, 32'd4));
    drd_req = 1'b0;
    @(negedge clk);
    check("t3d_gap", 256'({pulses(), mem_req}), '0);
    accept("t3i", 0, 1'b0, 32'h0080_0040, 3'd7, '0, '0);
    beats(8, 32'h2222_0000, 32'd1, 1'b1);
    check("t3i_pulse", 256'(pulses()), 256'(4'b1000));
    check("t3i_data", ret_data, line_of(32'h2222_0000, 32'd1));
    check("t3i_dret_hold", dret_data, line_of(32'h1111_0000, 32'h10));
    rd_req = 1'b0;
    @(negedge clk);
    check("t3i_once", 256'(pulses()), '0);

    // mem_ready held low for 5 cycles
    rd_addr = 32'h0000_0100; rd_req = 1'b1; c0 = cyc;
    accept("t4", 5, 1'b0, 32'h0000_0100, 3'd7, '0, '0);
    beats(8, 32'h3333_0000, 32'd4, 1'b1);
    check("t4_pulse", 256'(pulses()), 256'(4'b1000));
    check("t4_data", ret_data, line_of(32'h3333_0000, 32'd4));
    check("t4_lat", 256'(cyc - c0), 256'(15));
    rd_req = 1'b0;
    @(negedge clk);

    // Request left high through the done cycle is not re-issued
    iucache_addr_i = 32'h0000_0044; iucache_ren_i = 1'b1;
    accept("t5", 0, 1'b0, 32'h0000_0044, 3'd0, '0, '0);
    beats(1, 32'h55aa_55aa, 32'd0, 1'b1);
    check("t5_pulse", 256'(pulses()), 256'(4'b0010));
    check("t5_data", 256'(iucache_rdata_o), 256'(32'h55aa_55aa));
    @(negedge clk);
    iucache_ren_i = 1'b0;
    check("t5_once", 256'({pulses(), mem_req}), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_idle%0d", i), 256'({pulses(), mem_req}), '0);
    end

    // Reset while beat 4 of a refill is on the bus
    rd_addr = 32'h0080_0020; rd_req = 1'b1;
    accept("t6", 0, 1'b0, 32'h0080_0020, 3'd7, '0, '0);
    beats(4, 32'h4444_0000, 32'd1, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_0004; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rd_req = 1'b0;
    check("t6_mem", 256'({mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wstrb}), '0);
    check("t6_pulse", 256'(pulses()), '0);
    check("t6_ret", ret_data, '0);
    check("t6_dret", dret_data, '0);
    check("t6_iuc", 256'(iucache_rdata_o), '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6_quiet%0d", i), 256'({pulses(), mem_req}), '0);
    end

    // Refill after reset completes normally
    rd_addr = 32'h0000_1234; rd_req = 1'b1; c0 = cyc;
    accept("t7", 0, 1'b0, 32'h0000_1220, 3'd7, '0, '0);
    beats(8, 32'ha500_0000, 32'd1, 1'b1);
    check("t7_pulse", 256'(pulses()), 256'(4'b1000));
    check("t7_data", ret_data, line_of(32'ha500_0000, 32'd1));
    check("t7_lat", 256'(cyc - c0), 256'(10));
    rd_req = 1'b0;
    @(negedge clk);
    check("t7_once", 256'(pulses()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
